// File: rtl/inverse_pkg.sv
// Shared types and constants for the matrix-inverse sequencer and its multiplier arbiter.
package inverse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    PH_CHOL  = 2'd0,
    PH_LTINV = 2'd1,
    PH_MULT  = 2'd2,
    PH_IDLE  = 2'd3
  } phase_t;

  localparam logic [1:0] REQ_CHOL  = 2'd0;
  localparam logic [1:0] REQ_LTINV = 2'd1;
  localparam logic [1:0] REQ_DIV   = 2'd2;
  localparam logic [1:0] SEL_NONE  = 2'd3;

  // Index 'step' positions after 'base' in the three-entry ring.
  function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  function automatic logic [1:0] gnt_to_sel(input logic [2:0] gnt);
    logic [1:0] sel;
    case (gnt)
      3'b001:  sel = REQ_CHOL;
      3'b010:  sel = REQ_LTINV;
      3'b100:  sel = REQ_DIV;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/inverse_mult_arb.sv
// Owner-priority round-robin arbiter for the shared array_mult; grant is registered.
module inverse_mult_arb
  import inverse_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_i,
  input  logic [1:0] owner_i,
  input  logic       upd_i,
  input  logic       clr_i,
  output logic [2:0] gnt_o
);

  logic [2:0] gnt_q, gnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand1_s, cand2_s;
  logic [1:0] pick_idx_s;
  logic       pick_vld_s;

  // Phase owner first, then the ring starting just after the last winner.
  always_comb begin
    cand1_s    = rr_idx(ptr_q, 2'd1);
    cand2_s    = rr_idx(ptr_q, 2'd2);
    pick_vld_s = 1'b1;
    pick_idx_s = ptr_q;
    if (owner_i != SEL_NONE && req_i[owner_i]) begin
      pick_idx_s = owner_i;
    end else if (req_i[cand1_s]) begin
      pick_idx_s = cand1_s;
    end else if (req_i[cand2_s]) begin
      pick_idx_s = cand2_s;
    end else if (req_i[ptr_q]) begin
      pick_idx_s = ptr_q;
    end else begin
      pick_vld_s = 1'b0;
    end
  end

  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (clr_i) begin
      gnt_d = 3'b000;
      ptr_d = REQ_DIV;
    end else if (upd_i) begin
      if (pick_vld_s) begin
        gnt_d = 3'b001 << pick_idx_s;
        ptr_d = pick_idx_s;
      end else begin
        gnt_d = 3'b000;
        ptr_d = ptr_q;
      end
    end else begin
      gnt_d = gnt_q;
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= 3'b000;
      ptr_q <= REQ_DIV;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: rtl/inverse_sched.sv
// Start/done sequencer for Cholesky -> LT inverse -> final multiply, with mat_mult strobes and
// shared-multiplier arbitration. Define INVERSE_SCHED_PERF_EN to add the stall_cnt port.
module inverse_sched
  import inverse_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 229,
  parameter int MM_RST0   = 28,
  parameter int MM_RST1   = 98,
  parameter int MM_RST2   = 214,
  parameter int VEC_LO    = 89,
  parameter int VEC_HI    = 98,
  parameter int PH1_START = 29,
  parameter int PH2_START = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       phase,
  output logic             mm_rst,
  output logic             mm_mat_mode,
  input  logic [2:0]       mult_req,
  output logic [2:0]       mult_gnt,
  output logic [1:0]       mult_sel
`ifdef INVERSE_SCHED_PERF_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mm_rst_q, mm_rst_d;
  logic             run_s, run_en_s, last_s;
  phase_t           phase_s;
  logic [1:0]       owner_s;

  assign run_s    = (state_q == RUN);
  assign run_en_s = run_s & en;
  assign last_s   = (count_q == CNT_W'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start is only honoured from IDLE; it is dropped, not queued, elsewhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = (en && last_s) ? DONE : RUN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (run_en_s) begin
      count_d = last_s ? '0 : count_q + CNT_W'(1);
    end else if (run_s) begin
      count_d = count_q;
    end else begin
      count_d = '0;
    end
  end

  assign mm_rst_d = run_en_s & ((count_q == CNT_W'(MM_RST0)) ||
                                (count_q == CNT_W'(MM_RST1)) ||
                                (count_q == CNT_W'(MM_RST2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      mm_rst_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      mm_rst_q <= mm_rst_d;
    end
  end

  always_comb begin
    phase_s = PH_IDLE;
    if (!run_s) begin
      phase_s = PH_IDLE;
    end else if (count_q < CNT_W'(PH1_START)) begin
      phase_s = PH_CHOL;
    end else if (count_q < CNT_W'(PH2_START)) begin
      phase_s = PH_LTINV;
    end else begin
      phase_s = PH_MULT;
    end
  end

  always_comb begin
    owner_s = SEL_NONE;
    case (phase_s)
      PH_CHOL:  owner_s = REQ_CHOL;
      PH_LTINV: owner_s = REQ_LTINV;
      PH_MULT:  owner_s = REQ_DIV;
      default:  owner_s = SEL_NONE;
    endcase
  end

  // Clearing on the next state empties the grant in the very first DONE cycle.
  inverse_mult_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (mult_req),
    .owner_i (owner_s),
    .upd_i   (run_en_s),
    .clr_i   (state_d != RUN),
    .gnt_o   (mult_gnt)
  );

  assign count       = count_q;
  assign phase       = phase_s;
  assign mm_rst      = mm_rst_q;
  assign mm_mat_mode = ~(run_s && (count_q >= CNT_W'(VEC_LO)) && (count_q < CNT_W'(VEC_HI)));
  assign mult_sel    = gnt_to_sel(mult_gnt);

`ifdef INVERSE_SCHED_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = 16'h0000;
    end else if (run_s && !en && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'h0001;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_inverse_sched.sv
// Self-checking bench for inverse_sched: constant tables, directed corner sequences and a
// randomized run against a cycle-level reference model of the sequencing rules.
module tb_inverse_sched;

  logic       clk = 1'b0;
  logic       rst_n, start, en;
  logic [2:0] mult_req;
  logic       busy, done, mm_rst, mm_mat_mode;
  logic [7:0] count;
  logic [1:0] phase, mult_sel;
  logic [2:0] mult_gnt;
`ifdef INVERSE_SCHED_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  inverse_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .en          (en),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .phase       (phase),
    .mm_rst      (mm_rst),
    .mm_mat_mode (mm_mat_mode),
    .mult_req    (mult_req),
    .mult_gnt    (mult_gnt),
    .mult_sel    (mult_sel)
`ifdef INVERSE_SCHED_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Reference model state
  bit         m_run, m_done, m_mmrst;
  int         m_cnt, m_last, m_stall;
  logic [2:0] m_gnt;

  typedef struct {
    int         cnt;
    logic [1:0] ph;
    logic       mode;
    logic       rst;
  } vec_t;

  vec_t vecs[13];

  function automatic int phase_of(input int c);
    return (c < 29) ? 0 : (c < 99) ? 1 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_mmrst = 0; m_cnt = 0; m_last = 2; m_stall = 0; m_gnt = 3'b000;
  endtask

  task automatic model_step();
    int g;
    bit found;
    if (m_run) begin
      if (en) begin
        m_mmrst = (m_cnt == 28) || (m_cnt == 98) || (m_cnt == 214);
        if (m_cnt == 228) begin
          m_run = 0; m_done = 1; m_cnt = 0; m_gnt = 3'b000; m_last = 2;
        end else begin
          found = 0;
          g = phase_of(m_cnt);
          if (mult_req[g]) found = 1;
          else begin
            for (int k = 1; k <= 3; k++) begin
              g = (m_last + k) % 3;
              if (mult_req[g]) begin found = 1; break; end
            end
          end
          if (found) begin m_gnt = 3'(1 << g); m_last = g; end
          else m_gnt = 3'b000;
          m_cnt++;
        end
      end else begin
        m_mmrst = 0;
        if (m_stall < 65535) m_stall++;
      end
    end else if (m_done) begin
      m_done = 0; m_mmrst = 0; m_gnt = 3'b000; m_last = 2;
    end else begin
      m_mmrst = 0; m_gnt = 3'b000; m_last = 2;
      if (start) begin m_run = 1; m_stall = 0; end
    end
  endtask

  task automatic compare_all();
    logic [1:0] exp_sel;
    exp_sel = (m_gnt == 3'b001) ? 2'd0 : (m_gnt == 3'b010) ? 2'd1 : (m_gnt == 3'b100) ? 2'd2 : 2'd3;
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("count", count, m_cnt);
    check("phase", phase, m_run ? phase_of(m_cnt) : 3);
    check("mm_rst", mm_rst, m_mmrst);
    check("mm_mat_mode", mm_mat_mode, !(m_run && m_cnt >= 89 && m_cnt < 98));
    check("mult_gnt", mult_gnt, m_gnt);
    check("mult_sel", mult_sel, exp_sel);
`ifdef INVERSE_SCHED_PERF_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic wait_count(input int target);
    int n = 0;
    while ((count !== 8'(target) || busy !== 1'b1) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL wait_count: count %0d never reached, got %0d", target, count);
    end
  endtask

  task automatic run_until_done(output int at);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL done_timeout: done never seen, got done=%0b", done);
    end
    at = cyc;
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    int t0, t_done, n_done;

    vecs[0]  = '{0,   2'd0, 1'b1, 1'b0};
    vecs[1]  = '{28,  2'd0, 1'b1, 1'b0};
    vecs[2]  = '{29,  2'd1, 1'b1, 1'b1};
    vecs[3]  = '{30,  2'd1, 1'b1, 1'b0};
    vecs[4]  = '{88,  2'd1, 1'b1, 1'b0};
    vecs[5]  = '{89,  2'd1, 1'b0, 1'b0};
    vecs[6]  = '{97,  2'd1, 1'b0, 1'b0};
    vecs[7]  = '{98,  2'd1, 1'b1, 1'b0};
    vecs[8]  = '{99,  2'd2, 1'b1, 1'b1};
    vecs[9]  = '{100, 2'd2, 1'b1, 1'b0};
    vecs[10] = '{214, 2'd2, 1'b1, 1'b0};
    vecs[11] = '{215, 2'd2, 1'b1, 1'b1};
    vecs[12] = '{228, 2'd2, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; en = 1'b1; mult_req = 3'b000;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_sel", mult_sel, 2'd3);
    rst_n = 1'b1;
    tick();

    // Step/phase/strobe table over one clean run, then done latency
    pulse_start(t0);
    check("busy_after_start", busy, 1'b1);
    foreach (vecs[i]) begin
      wait_count(vecs[i].cnt);
      check($sformatf("tbl_phase@%0d", vecs[i].cnt), phase, vecs[i].ph);
      check($sformatf("tbl_mode@%0d", vecs[i].cnt), mm_mat_mode, vecs[i].mode);
      check($sformatf("tbl_mmrst@%0d", vecs[i].cnt), mm_rst, vecs[i].rst);
    end
    run_until_done(t_done);
    check("done_latency", t_done - t0, 229);
    check("count_at_done", count, 8'd0);
    tick();
    check("done_one_cycle", done, 1'b0);

    // Stall of 10 cycles at count 50
    pulse_start(t0);
    wait_count(50);
    en = 1'b0;
    repeat (10) tick();
    check("count_frozen", count, 8'd50);
    en = 1'b1;
    run_until_done(t_done);
    check("stalled_latency", t_done - t0, 239);
`ifdef INVERSE_SCHED_PERF_EN
    check("stall_cnt_10", stall_cnt, 16'd10);
    repeat (3) tick();
    check("stall_cnt_hold", stall_cnt, 16'd10);
`endif
    tick();

    // start with en low: RUN entered but count stays 0
    en = 1'b0;
    pulse_start(t0);
    check("start_en0_busy", busy, 1'b1);
    tick();
    check("start_en0_count", count, 8'd0);
    en = 1'b1;
    run_until_done(t_done);
    tick();

    // Owner priority and rotation
    mult_req = 3'b111;
    pulse_start(t0);
    check("gnt_latency", mult_gnt, 3'b000);
    wait_count(5);
    check("gnt_chol", mult_gnt, 3'b001);
    wait_count(150);
    check("gnt_mult", mult_gnt, 3'b100);
    mult_req = 3'b011;
    tick(); check("rot0", mult_gnt, 3'b001);
    tick(); check("rot1", mult_gnt, 3'b010);
    tick(); check("rot2", mult_gnt, 3'b001);
    mult_req = 3'b000;
    tick(); check("gnt_none", mult_gnt, 3'b000);
    mult_req = 3'b100;
    run_until_done(t_done);
    check("gnt_clear_in_done", mult_gnt, 3'b000);
    mult_req = 3'b000;
    tick();

    // Asynchronous reset mid-run
    mult_req = 3'b111;
    pulse_start(t0);
    wait_count(120);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_count", count, 8'd0);
    check("rst_gnt", mult_gnt, 3'b000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("no_restart", busy, 1'b0);
    mult_req = 3'b000;

    // start while busy is ignored
    pulse_start(t0);
    wait_count(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(t_done);
    check("ignored_start_latency", t_done - t0, 229);
    n_done = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check("single_done", n_done, 0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 49) == 0);
      en       = ($urandom_range(0, 9) != 0);
      mult_req = 3'($urandom_range(0, 7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
